// File: rtl/target_compare_scheduler.sv
// target_compare_scheduler: expands compact nBits into a 256-bit target byte-serially,
// then shares one hash<=target comparator between NUM_CORES cores via round-robin.
// Ports: wb_clk_i/wb_rst_i (sync active-high); nbits_i/nbits_valid_i/nbits_ready_o;
// target_o/target_vld_o/nbits_err_o; req_i/hash_i in, ack_o/hit_o one-cycle pulses out.
// Optional: TARGET_SCHED_STATS_EN adds cmp_count_o/hit_count_o counters.
`timescale 1ns/1ps
module target_compare_scheduler #(
  parameter int NUM_CORES = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [31:0]              nbits_i,
  input  logic                     nbits_valid_i,
  output logic                     nbits_ready_o,
  output logic [255:0]             target_o,
  output logic                     target_vld_o,
  output logic                     nbits_err_o,
  input  logic [NUM_CORES-1:0]     req_i,
  input  logic [256*NUM_CORES-1:0] hash_i,
  output logic [NUM_CORES-1:0]     ack_o,
  output logic [NUM_CORES-1:0]     hit_o
`ifdef TARGET_SCHED_STATS_EN
  ,
  output logic [31:0]              cmp_count_o,
  output logic [31:0]              hit_count_o
`endif
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_READY
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           e_q, e_d;
  logic [23:0]          m_q, m_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [255:0]         target_q, target_d;
  logic                 vld_q, vld_d;
  logic                 err_q, err_d;
  logic [NUM_CORES-1:0] ack_q, ack_d;
  logic [NUM_CORES-1:0] hit_q, hit_d;
  logic [PW-1:0]        ptr_q, ptr_d;

  logic                 accept;
  logic [NUM_CORES-1:0] elig;
  logic                 found;
  int                   gidx;
  int                   bi;
  logic [7:0]           byte_v;

  assign nbits_ready_o = !wb_rst_i && (state_q != S_EXPAND);
  assign accept        = nbits_valid_i && nbits_ready_o;
  assign target_o      = target_q;
  assign target_vld_o  = vld_q;
  assign nbits_err_o   = err_q;
  assign ack_o         = ack_q;
  assign hit_o         = hit_q;

  // Mantissa byte landing at target byte cnt_q; signed offset so E<3 truncates.
  always_comb begin
    bi     = int'(cnt_q) - (int'(e_q) - 3);
    byte_v = '0;
    if (!err_q) begin
      case (bi)
        0:       byte_v = m_q[7:0];
        1:       byte_v = m_q[15:8];
        2:       byte_v = m_q[23:16];
        default: byte_v = '0;
      endcase
    end
  end

  // A core acked this cycle is not eligible, so it cannot be regranted back-to-back.
  always_comb begin
    elig  = req_i & ~ack_q;
    found = 1'b0;
    gidx  = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % NUM_CORES;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    e_d      = e_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    vld_d    = vld_q;
    err_d    = err_q;
    ptr_d    = ptr_q;
    ack_d    = '0;
    hit_d    = '0;
    unique case (state_q)
      S_IDLE: ;
      S_EXPAND: begin
        target_d[{cnt_q, 3'b000} +: 8] = byte_v;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = S_READY;
          vld_d   = 1'b1;
        end
      end
      S_READY: begin
        if (!accept && found) begin
          ack_d[gidx] = 1'b1;
          hit_d[gidx] = !err_q && (hash_i[256*gidx +: 256] <= target_q);
          ptr_d = (gidx == NUM_CORES - 1) ? '0 : PW'(gidx + 1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // New nBits wins over arbitration; invalid words still walk all 32 bytes as zero.
    if (accept) begin
      state_d  = S_EXPAND;
      e_d      = nbits_i[31:24];
      m_d      = nbits_i[23:0];
      err_d    = (nbits_i[31:24] > 8'd32) || nbits_i[23];
      vld_d    = 1'b0;
      cnt_d    = 5'd31;
      target_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      e_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      ack_q    <= '0;
      hit_q    <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      e_q      <= e_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      hit_q    <= hit_d;
      ptr_q    <= ptr_d;
    end
  end

`ifdef TARGET_SCHED_STATS_EN
  logic [31:0] cmp_cnt_q;
  logic [31:0] hit_cnt_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || accept) begin
      cmp_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      if (|ack_q)
        cmp_cnt_q <= cmp_cnt_q + 32'd1;
      if (|(ack_q & hit_q))
        hit_cnt_q <= hit_cnt_q + 32'd1;
    end
  end

  assign cmp_count_o = cmp_cnt_q;
  assign hit_count_o = hit_cnt_q;
`endif

endmodule
